tl45_prefetch_queue: RTL and testbench
======================================

# tl45_prefetch_queue

Pipelined Wishbone instruction prefetcher with a parametrised output queue: the next generation of the TL45 single-shot fetch unit. Keeps up to DEPTH requests in flight or buffered, retires instructions in order, and tags bus errors per entry instead of silently retrying. Flushes on a PC override. Sits between the instruction Wishbone master port and the TL45 decode stage.

## Interface
- DEPTH, 4: queue entries plus in-flight requests combined; power of two, 2..16.
- RESET_PC, 32'h0000_0000: fetch address after reset; word aligned.
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_pipe_stall  in  1  decode not accepting; an entry is consumed when o_valid && !i_pipe_stall
- i_new_pc  in  1  PC override strobe; flush and refetch
- i_pc  in  32  override target; bits [1:0] ignored
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined master; we is always 0
- o_wb_addr  out  30  word address
- o_wb_data  out  32  constant 0
- o_wb_sel  out  4  constant 4'hF
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave responses
- i_wb_data  in  32  read data
- o_valid  out  1  head entry present
- o_pc  out  32  PC of head entry
- o_inst  out  32  instruction of head entry; 0 when o_err
- o_err  out  1  head entry is a bus error

## Operation
- State: req_pc (next address to issue), ack_pc (PC of next response), inflight (issued, unacked), count (queue occupancy), halted flag, FIFO of {pc, inst, err}.
- Reset: req_pc = ack_pc = RESET_PC, inflight = count = 0, halted = 0; all outputs 0.
- States IDLE, FETCH, DRAIN:
  - IDLE -> FETCH when !halted and count + inflight < DEPTH; cyc asserted.
  - FETCH: stb high while count + inflight + (stb accepted this cycle) < DEPTH and !halted. Accepted request (stb && !stall): req_pc += 4, inflight += 1. Stalled stb holds address.
  - FETCH -> DRAIN when no stb is pending and slots are exhausted or halted; cyc held until inflight = 0, then -> IDLE with cyc = 0.
- Ack: push {ack_pc, i_wb_data, 0}, ack_pc += 4, inflight -= 1.
- Err (priority over ack): push {ack_pc, 0, 1}, set halted; stb dropped immediately; remaining acks of the cycle still pushed; no new issue until i_new_pc.
- Pop and push in the same cycle both take effect; full queue cannot receive a push because slots are reserved at issue.
- i_new_pc (highest priority below reset): cyc and stb forced low on the next edge (bus abort), FIFO cleared, inflight = 0, halted = 0, req_pc = ack_pc = {i_pc[31:2], 2'b00}, state IDLE. Ack/err in the same cycle is discarded. Pop in the same cycle is discarded.
- Widths: PC arithmetic modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0.

## Timing
- All Wishbone outputs and o_valid/o_pc/o_inst/o_err registered.
- Reset release -> cycle 1 cyc = stb = 1, addr = RESET_PC[31:2].
- Zero-wait slave with stall = 0: one request per cycle; ack in cycle N -> o_valid in N+1.
- i_new_pc in cycle N -> cyc = 0 in N+1, cyc = stb = 1 with new address in N+2.
- Sustained throughput one instruction per cycle when the slave acks every cycle and DEPTH >= 2 + slave latency.

## Structure
- Package tl45_prefetch_pkg: state enum, fifo entry struct {pc, inst, err}, ENTRY_W constant.
- Sub-module tl45_sync_fifo (parametrised width/depth, first-word-fall-through, synchronous clear) holds the queue; the control FSM and counters stay in tl45_prefetch_queue.

## Test plan
- Reset, zero-wait slave returning addr*4 as data, no stall -> o_pc 0, 4, 8, 12 on consecutive cycles, o_inst matching.
- i_pipe_stall held 20 cycles, DEPTH=4 -> exactly 4 requests issued, count 4, stb low, cyc drops once inflight 0; release -> in-order drain then refetch from 0x10.
- i_wb_stall high 3 cycles on first request -> addr held 0 throughout, req_pc advances only on accept.
- Err on request at 0x8 -> entries 0x0, 0x4 valid, entry 0x8 with o_err = 1, o_inst = 0; no further stb until i_new_pc.
- i_new_pc = 0x100 with 3 requests in flight and ack same cycle -> ack dropped, queue empty, next cycle cyc = 0, following cycle addr = 0x40, first o_pc = 0x100.
- i_reset asserted mid-burst asynchronously -> all outputs 0 immediately, restart at RESET_PC.

Source files
------------

// File: rtl/tl45_prefetch_pkg.sv
// Shared types for the TL45 prefetch queue: control FSM states and the
// queue entry layout.
package tl45_prefetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/tl45_sync_fifo.sv
// First-word-fall-through synchronous FIFO with synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module tl45_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;

  assign w_pop = i_pop && (r_count != '0);

  // NOTE: storage is deliberately not reset; readers qualify o_data with o_empty.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/tl45_prefetch_queue.sv
// Pipelined Wishbone instruction prefetcher: issues up to DEPTH reads ahead,
// queues responses in order, tags bus errors per entry, flushes on PC override.
module tl45_prefetch_queue
  import tl45_prefetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_new_pc,
  input  logic [31:0] i_pc,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [29:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_data,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t      r_state, w_state_next;
  logic        r_cyc, r_stb, r_halted;
  logic        w_cyc_next, w_stb_next;
  logic [31:0] r_req_pc, r_ack_pc;
  logic [CW-1:0] r_inflight;

  logic          w_accept, w_resp, w_pop, w_halted_next, w_issue, w_empty;
  logic [CW-1:0] w_count, w_count_next, w_inflight_next;
  logic [CW:0]   w_occ_next;
  fifo_entry_t   w_push_entry, w_head;
  logic          w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = ^i_pc[1:0];

  assign w_accept = r_stb && !i_wb_stall;
  assign w_resp   = r_cyc && (i_wb_ack || i_wb_err) && !i_new_pc;
  assign w_pop    = o_valid && !i_pipe_stall && !i_new_pc;

  // Errors win over data: the entry carries a zero instruction and the flag.
  assign w_push_entry.pc   = r_ack_pc;
  assign w_push_entry.inst = i_wb_err ? 32'h0 : i_wb_data;
  assign w_push_entry.err  = i_wb_err;

  // Slots are reserved at issue, so queue plus in-flight never exceeds DEPTH.
  assign w_inflight_next = r_inflight + CW'(w_accept) - CW'(w_resp);
  assign w_count_next    = w_count + CW'(w_resp) - CW'(w_pop);
  assign w_occ_next      = {1'b0, w_count_next} + {1'b0, w_inflight_next};
  assign w_halted_next   = r_halted || (w_resp && i_wb_err);
  assign w_issue         = !w_halted_next && (w_occ_next < (CW+1)'(DEPTH));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cyc_next   = r_cyc;
    w_stb_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cyc_next = 1'b0;
        if (w_issue) begin
          w_state_next = ST_FETCH;
          w_cyc_next   = 1'b1;
          w_stb_next   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (w_issue) begin
          w_cyc_next = 1'b1;
          w_stb_next = 1'b1;
        end else if (w_inflight_next != '0) begin
          w_state_next = ST_DRAIN;
          w_cyc_next   = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
          w_cyc_next   = 1'b0;
        end
      end
      ST_DRAIN: begin
        w_cyc_next = (w_inflight_next != '0);
        if (w_inflight_next == '0) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cyc_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_halted   <= 1'b0;
      r_inflight <= '0;
      r_req_pc   <= RESET_PC;
      r_ack_pc   <= RESET_PC;
    end else if (i_new_pc) begin
      // Bus abort: outstanding responses are simply forgotten.
      r_state    <= ST_IDLE;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_halted   <= 1'b0;
      r_inflight <= '0;
      r_req_pc   <= {i_pc[31:2], 2'b00};
      r_ack_pc   <= {i_pc[31:2], 2'b00};
    end else begin
      r_state    <= w_state_next;
      r_cyc      <= w_cyc_next;
      r_stb      <= w_stb_next;
      r_halted   <= w_halted_next;
      r_inflight <= w_inflight_next;
      if (w_accept) r_req_pc <= r_req_pc + 32'd4;
      if (w_resp)   r_ack_pc <= r_ack_pc + 32'd4;
    end
  end

  tl45_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (i_new_pc),
    .i_push  (w_resp),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_wb_cyc  = r_cyc;
  assign o_wb_stb  = r_stb;
  assign o_wb_we   = 1'b0;
  assign o_wb_addr = r_stb ? r_req_pc[31:2] : 30'h0;
  assign o_wb_data = 32'h0;
  assign o_wb_sel  = 4'hF;

  assign o_valid = !w_empty;
  assign o_pc    = o_valid ? w_head.pc   : 32'h0;
  assign o_inst  = o_valid ? w_head.inst : 32'h0;
  assign o_err   = o_valid && w_head.err;

endmodule

// File: tb/tb_tl45_prefetch_queue.sv
// Self-checking bench for tl45_prefetch_queue: directed corner cases, a flush
// vector table, and randomized traffic against an in-order stream model.
module tb_tl45_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        i_reset, i_pipe_stall, i_new_pc;
  logic [31:0] i_pc;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [29:0] o_wb_addr;
  logic [31:0] o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_stall, i_wb_err;
  logic [31:0] i_wb_data;
  logic        o_valid;
  logic [31:0] o_pc, o_inst;
  logic        o_err;

  always #5 clk = ~clk;

  tl45_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_pipe_stall(i_pipe_stall),
    .i_new_pc(i_new_pc), .i_pc(i_pc),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data),
    .o_valid(o_valid), .o_pc(o_pc), .o_inst(o_inst), .o_err(o_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] pc_in;
    logic [29:0] exp_addr;
    logic [31:0] exp_pc0;
    logic [31:0] exp_pc1;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [29:0] sq[$];       // accepted word addresses awaiting a response
  exp_t        exp_q[$];    // entries the DUT must hold, in order
  bit          slave_hold, rnd_mode, chk_stream, err_en, model_halted, resp_valid;
  logic [29:0] err_addr, resp_addr;
  logic [31:0] model_pc;
  int          n_acc, n_consumed;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: observe/score before the edge, update the model after it,
  // then let the slave drive its response for the new cycle.
  task automatic tick();
    bit          acc, flush;
    logic [29:0] acc_addr;
    exp_t        e;
    acc      = o_wb_cyc && o_wb_stb && !i_wb_stall;
    acc_addr = o_wb_addr;
    flush    = i_new_pc;
    if (model_halted) check("halt_no_stb", o_wb_stb, 0);
    if (chk_stream) begin
      check("occupancy", (exp_q.size() + sq.size() + (resp_valid ? 1 : 0)) <= DEPTH, 1);
      if (o_valid && !i_pipe_stall && !flush) begin
        check("stream_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("stream_pc_model", o_pc, model_pc);
          check("stream_pc", o_pc, e.pc);
          check("stream_inst", o_inst, e.inst);
          check("stream_err", o_err, e.err);
          model_pc += 32'd4;
          n_consumed++;
        end
      end
    end
    @(posedge clk); #1;
    if (flush) begin
      sq.delete();
      exp_q.delete();
      model_pc     = {i_pc[31:2], 2'b00};
      model_halted = 1'b0;
    end else begin
      if (resp_valid) begin
        e.pc   = {resp_addr, 2'b00};
        e.err  = i_wb_err;
        e.inst = i_wb_err ? 32'h0 : {resp_addr, 2'b00};
        exp_q.push_back(e);
        if (i_wb_err) model_halted = 1'b1;
      end
      if (acc) begin
        sq.push_back(acc_addr);
        n_acc++;
      end
    end
    i_wb_ack   = 1'b0;
    i_wb_err   = 1'b0;
    i_wb_data  = 32'h0;
    resp_valid = 1'b0;
    if (rnd_mode) i_wb_stall = ($urandom_range(3) == 0);
    if (!slave_hold && sq.size() > 0 && (!rnd_mode || $urandom_range(3) != 0)) begin
      resp_addr  = sq.pop_front();
      resp_valid = 1'b1;
      if ((err_en && resp_addr == err_addr) || (rnd_mode && $urandom_range(39) == 0))
        i_wb_err = 1'b1;
      else begin
        i_wb_ack  = 1'b1;
        i_wb_data = {resp_addr, 2'b00};
      end
    end
  endtask

  task automatic wait_valid(string name, int max_cycles);
    for (int i = 0; i < max_cycles && !o_valid; i++) tick();
    check(name, o_valid, 1);
  endtask

  task automatic clear_inputs();
    i_pipe_stall = 0; i_new_pc = 0; i_pc = 0;
    i_wb_ack = 0; i_wb_err = 0; i_wb_stall = 0; i_wb_data = 0;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    sq.delete();
    exp_q.delete();
    resp_valid   = 0;
    model_halted = 0;
    model_pc     = 32'h0;
    n_acc        = 0;
    i_reset      = 1'b0;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{32'h0000_0100, 30'h0000_0040, 32'h0000_0100, 32'h0000_0104};
    vecs[1] = '{32'h0000_0203, 30'h0000_0080, 32'h0000_0200, 32'h0000_0204};
    vecs[2] = '{32'hFFFF_FFFC, 30'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h1234_5679, 30'h048D_159E, 32'h1234_5678, 32'h1234_567C};
    slave_hold = 0; rnd_mode = 0; chk_stream = 0; err_en = 0; err_addr = '0;
    resp_valid = 0; resp_addr = '0; model_halted = 0; model_pc = 0;
    n_acc = 0; n_consumed = 0;

    // Reset state.
    i_reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    check("rst_cyc", o_wb_cyc, 0);
    check("rst_stb", o_wb_stb, 0);
    check("rst_we", o_wb_we, 0);
    check("rst_addr", o_wb_addr, 0);
    check("rst_valid", o_valid, 0);
    check("rst_pc", o_pc, 0);
    check("rst_inst", o_inst, 0);
    check("rst_err", o_err, 0);

    // Zero-wait slave, no stall: o_pc 0,4,8,12 back to back.
    do_reset();
    tick();
    check("t1_cyc", o_wb_cyc, 1);
    check("t1_stb", o_wb_stb, 1);
    check("t1_addr", o_wb_addr, 0);
    tick();
    check("t1_not_yet_valid", o_valid, 0);
    tick();
    check("t1_valid_c3", o_valid, 1);
    for (int k = 0; k < 4; k++) begin
      check("t1_pc", o_pc, 32'(4 * k));
      check("t1_inst", o_inst, 32'(4 * k));
      tick();
    end

    // Decode stalled: only DEPTH requests go out, bus idles, ordered drain.
    do_reset();
    i_pipe_stall = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("t2_requests", n_acc, DEPTH);
    check("t2_stb_low", o_wb_stb, 0);
    check("t2_cyc_low", o_wb_cyc, 0);
    check("t2_valid", o_valid, 1);
    check("t2_head", o_pc, 0);
    i_pipe_stall = 1'b0;
    tick();
    check("t2_refetch_stb", o_wb_stb, 1);
    check("t2_refetch_addr", o_wb_addr, 30'h4);
    check("t2_pc4", o_pc, 32'h4);
    tick();
    check("t2_pc8", o_pc, 32'h8);
    tick();
    check("t2_pc12", o_pc, 32'hC);
    tick();
    check("t2_pc16_valid", o_valid, 1);
    check("t2_pc16", o_pc, 32'h10);

    // Slave stall on the first request holds the address.
    do_reset();
    i_wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_stb_held", o_wb_stb, 1);
      check("t3_addr_held", o_wb_addr, 0);
    end
    check("t3_no_accept", n_acc, 0);
    i_wb_stall = 1'b0;
    tick();
    check("t3_one_accept", n_acc, 1);
    check("t3_addr_adv", o_wb_addr, 30'h1);

    // Bus error at 0x8: tagged entry, then no issue until a new PC.
    do_reset();
    err_en   = 1'b1;
    err_addr = 30'h2;
    tick();
    wait_valid("t4_first_valid", 10);
    check("t4_pc0", o_pc, 32'h0);
    check("t4_err0", o_err, 0);
    tick();
    check("t4_pc4", o_pc, 32'h4);
    check("t4_inst4", o_inst, 32'h4);
    check("t4_err4", o_err, 0);
    tick();
    check("t4_valid8", o_valid, 1);
    check("t4_pc8", o_pc, 32'h8);
    check("t4_inst8", o_inst, 32'h0);
    check("t4_err8", o_err, 1);
    for (int k = 0; k < 12; k++) tick();
    check("t4_cyc_idle", o_wb_cyc, 0);
    err_en   = 1'b0;
    i_new_pc = 1'b1;
    i_pc     = 32'h40;
    tick();
    i_new_pc = 1'b0;
    check("t4_flush_cyc", o_wb_cyc, 0);
    tick();
    check("t4_restart_stb", o_wb_stb, 1);
    check("t4_restart_addr", o_wb_addr, 30'h10);

    // New PC with three requests in flight and an ack in the same cycle.
    do_reset();
    slave_hold = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    slave_hold = 1'b0;
    tick();
    check("t5_inflight", n_acc, 3);
    i_new_pc = 1'b1;
    i_pc     = 32'h100;
    tick();
    i_new_pc = 1'b0;
    check("t5_cyc_abort", o_wb_cyc, 0);
    check("t5_stb_abort", o_wb_stb, 0);
    check("t5_queue_empty", o_valid, 0);
    tick();
    check("t5_new_stb", o_wb_stb, 1);
    check("t5_new_addr", o_wb_addr, 30'h40);
    wait_valid("t5_first_valid", 10);
    check("t5_first_pc", o_pc, 32'h100);
    check("t5_first_inst", o_inst, 32'h100);

    // Flush target table.
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    foreach (vecs[v]) begin
      i_new_pc = 1'b1;
      i_pc     = vecs[v].pc_in;
      tick();
      i_new_pc = 1'b0;
      check("vec_cyc_low", o_wb_cyc, 0);
      tick();
      check("vec_stb", o_wb_stb, 1);
      check("vec_addr", o_wb_addr, vecs[v].exp_addr);
      wait_valid("vec_valid", 10);
      check("vec_pc0", o_pc, vecs[v].exp_pc0);
      check("vec_inst0", o_inst, vecs[v].exp_pc0);
      tick();
      check("vec_valid1", o_valid, 1);
      check("vec_pc1", o_pc, vecs[v].exp_pc1);
    end

    // Asynchronous reset mid-burst.
    do_reset();
    for (int k = 0; k < 6; k++) tick();
    #3;
    i_reset = 1'b1;
    #1;
    check("t6_cyc", o_wb_cyc, 0);
    check("t6_stb", o_wb_stb, 0);
    check("t6_addr", o_wb_addr, 0);
    check("t6_valid", o_valid, 0);
    check("t6_pc", o_pc, 0);
    check("t6_inst", o_inst, 0);
    check("t6_err", o_err, 0);
    do_reset();
    tick();
    check("t6_restart_stb", o_wb_stb, 1);
    check("t6_restart_addr", o_wb_addr, 0);
    wait_valid("t6_valid_again", 10);
    check("t6_first_pc", o_pc, 0);

    // Randomized traffic against the in-order stream model.
    do_reset();
    rnd_mode   = 1'b1;
    chk_stream = 1'b1;
    n_consumed = 0;
    for (int c = 0; c < 4000; c++) begin
      i_new_pc = ($urandom_range(63) == 0);
      if (i_new_pc)
        i_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      i_pipe_stall = ($urandom_range(2) == 0);
      tick();
      i_new_pc = 1'b0;
    end
    rnd_mode   = 1'b0;
    chk_stream = 1'b0;
    check("rnd_progress", n_consumed > 300, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
